// File: rtl/bench_pkg.sv
// Shared constants and FSM state encoding for the response MISR.
package bench_pkg;
    localparam int             WIDTH = 19;
    localparam logic [WIDTH-1:0] POLY  = 19'h00027;
    localparam logic [WIDTH-1:0] SEED  = 19'h00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/misr_step.sv
// One Galois MISR update: shift, fold the MSB back through POLY, absorb data.
module misr_step #(
    parameter int               WIDTH = bench_pkg::WIDTH,
    parameter logic [WIDTH-1:0] POLY  = bench_pkg::POLY
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] nxt
);
    assign nxt = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
endmodule

// File: rtl/resp_misr_19.sv
// Response compactor: folds a counted run of benchmark output words into a
// MISR signature and compares the result against a golden value.
module resp_misr_19 #(
    parameter int               WIDTH = bench_pkg::WIDTH,
    parameter logic [WIDTH-1:0] POLY  = bench_pkg::POLY,
    parameter logic [WIDTH-1:0] SEED  = bench_pkg::SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_patterns,
    input  logic [WIDTH-1:0] golden_sig,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      count
);
    bench_pkg::state_t state, state_nxt;

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_nxt;
    logic [15:0]      cnt_q;
    logic [15:0]      npat_q;
    logic             pass_q;
    logic             xfer;
    logic             last;
    logic             launch;

    misr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
        .sig  (sig_q),
        .data (in_data),
        .nxt  (sig_nxt)
    );

    assign xfer   = in_valid && (state == bench_pkg::RUN);
    assign last   = xfer && (cnt_q == npat_q - 16'd1);
    assign launch = start && (state != bench_pkg::RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            bench_pkg::IDLE,
            bench_pkg::DONE: if (start) state_nxt = (num_patterns == 16'd0) ? bench_pkg::DONE
                                                                             : bench_pkg::RUN;
            bench_pkg::RUN:  if (last)  state_nxt = bench_pkg::DONE;
            default:                    state_nxt = bench_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= bench_pkg::IDLE;
        else     state <= state_nxt;
    end

    // Datapath registers; frozen in DONE until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q  <= SEED;
            cnt_q  <= '0;
            npat_q <= '0;
            pass_q <= 1'b0;
        end else if (launch) begin
            sig_q  <= SEED;
            cnt_q  <= '0;
            npat_q <= num_patterns;
            pass_q <= (num_patterns == 16'd0) && (SEED == golden_sig);
        end else if (xfer) begin
            sig_q <= sig_nxt;
            cnt_q <= cnt_q + 16'd1;
            if (last) pass_q <= (sig_nxt == golden_sig);
        end
    end

    assign in_ready  = (state == bench_pkg::RUN);
    assign busy      = (state == bench_pkg::RUN);
    assign done      = (state == bench_pkg::DONE);
    assign pass      = pass_q;
    assign signature = sig_q;
    assign count     = cnt_q;
endmodule

// File: tb/tb_resp_misr_19.sv
// Scoreboard bench for resp_misr_19: expected signatures are queued at run launch.
module tb_resp_misr_19;
    localparam int               W    = 19;
    localparam logic [W-1:0]     POLY = 19'h00027;
    localparam logic [W-1:0]     SEED = 19'h00000;

    logic         clk = 1'b0;
    logic         rst, start, in_valid;
    logic [15:0]  num_patterns;
    logic [W-1:0] golden_sig, in_data;
    logic         in_ready, busy, done, pass;
    logic [W-1:0] signature;
    logic [15:0]  count;

    resp_misr_19 dut (
        .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
        .golden_sig(golden_sig), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .count(count)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_sig_q[$];
    logic         exp_pass_q[$];
    logic [15:0]  exp_cnt_q[$];
    logic [W-1:0] wd[16];
    int           gp[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = s << 1;
        if (s[W-1]) r = r ^ POLY;
        return r ^ d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [W-1:0] gold, input bit poke);
        logic [W-1:0] m;
        logic [W-1:0] es;
        logic         ep;
        logic [15:0]  ec;
        int           t;
        m = SEED;
        for (int i = 0; i < n; i++) m = model(m, wd[i]);
        exp_sig_q.push_back(m);
        exp_pass_q.push_back(m == gold);
        exp_cnt_q.push_back(16'(n));
        start = 1'b1; num_patterns = 16'(n); golden_sig = gold;
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gp[i]; g++) begin
                in_valid = 1'b0; in_data = W'($urandom); start = poke;
                num_patterns = 16'd0;
                step();
                chk("stall_cnt", 32'(count), 32'(i));
                chk("stall_busy", 32'(busy), 32'd1);
            end
            start = 1'b0;
            in_valid = 1'b1; in_data = wd[i];
            chk("in_ready", 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
        end
        t = 0;
        while (!done && t < 20) begin
            step();
            t++;
        end
        chk("done", 32'(done), 32'd1);
        chk("done_lat", 32'(t), 32'd0);
        es = exp_sig_q.pop_front();
        ep = exp_pass_q.pop_front();
        ec = exp_cnt_q.pop_front();
        chk("signature", 32'(signature), 32'(es));
        chk("pass", 32'(pass), 32'(ep));
        chk("count", 32'(count), 32'(ec));
        in_valid = 1'b1; in_data = W'($urandom); golden_sig = ~gold;
        repeat (3) step();
        in_valid = 1'b0;
        chk("frz_sig", 32'(signature), 32'(es));
        chk("frz_pass", 32'(pass), 32'(ep));
        chk("frz_cnt", 32'(count), 32'(ec));
        chk("frz_rdy", 32'(in_ready), 32'd0);
    endtask

    initial begin
        logic [W-1:0] m;
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = '1;
        num_patterns = 16'd3; golden_sig = '0;
        step(); step();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_sig", 32'(signature), 32'(SEED));
        chk("rst_cnt", 32'(count), 32'd0);

        for (int i = 0; i < 16; i++) gp[i] = 0;

        wd[0] = 19'h00001;
        run(1, 19'h00001, 1'b0);
        chk("n1_sig", 32'(signature), 32'h00001);

        wd[0] = 19'h00001; wd[1] = 19'h00001;
        run(2, 19'h00004, 1'b0);
        chk("n2_sig", 32'(signature), 32'h00003);
        chk("n2_pass", 32'(pass), 32'd0);

        wd[0] = 19'h40000; wd[1] = 19'h00000;
        run(2, 19'h00027, 1'b0);
        chk("fb_sig", 32'(signature), 32'h00027);

        wd[0] = 19'h12345; wd[1] = 19'h7abcd; wd[2] = 19'h40001;
        run(3, 19'h0, 1'b0);
        m = signature;
        gp[0] = 0; gp[1] = 2; gp[2] = 5;
        run(3, 19'h0, 1'b1);
        chk("gap_same", 32'(signature), 32'(m));

        for (int i = 0; i < 16; i++) gp[i] = 0;
        run(0, 19'h00000, 1'b0);
        chk("n0_sig", 32'(signature), 32'h00000);
        chk("n0_pass", 32'(pass), 32'd1);

        // Reset in the middle of a 4-word run, with start and a transfer pending.
        start = 1'b1; num_patterns = 16'd4; golden_sig = '0;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = W'($urandom);
            step();
        end
        chk("mid_cnt", 32'(count), 32'd2);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_cnt", 32'(count), 32'd0);
        chk("mrst_sig", 32'(signature), 32'(SEED));
        chk("mrst_pass", 32'(pass), 32'd0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 16));
            m = SEED;
            for (int i = 0; i < n; i++) begin
                wd[i] = W'($urandom);
                gp[i] = int'($urandom_range(0, 3));
                m = model(m, wd[i]);
            end
            run(n, (r % 2 == 0) ? m : (m ^ 19'h00100), r[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
